// File: rtl/rram_prog_pkg.sv
// Shared types and default timing constants for the RRAM configuration-cell programming sequencer.
package rram_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5
  } prog_state_e;

  localparam int unsigned DEF_NUM_BITS  = 16;
  localparam int unsigned DEF_SETUP_CYC = 2;
  localparam int unsigned DEF_PULSE_CYC = 4;
  localparam int unsigned DEF_HOLD_CYC  = 1;
  localparam int unsigned DEF_MAX_RETRY = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rram_prog_sequencer_timer.sv
// Loadable phase down-counter; expired is high once the loaded count has run down to zero.
module prog_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_r;

  // load on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign expired = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/rram_prog_sequencer.sv
// Programs a captured configuration word into a column of 2BL/2WL RRAM cells, one cell at a time.
// Define RRAM_PROG_VERIFY_EN to add the per-cell readback-verify-retry loop.
module rram_prog_sequencer
  import rram_prog_pkg::*;
#(
  parameter int unsigned NUM_BITS  = DEF_NUM_BITS,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
  localparam int unsigned IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_BITS-1:0]   cfg_data,
  input  logic [NUM_BITS-1:0]   dout_i,
  output logic [2*NUM_BITS-1:0] bl_o,
  output logic [2*NUM_BITS-1:0] wl_o,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      err_idx
);

  localparam int unsigned CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  prog_state_e           state_r, next_s;
  logic [NUM_BITS-1:0]   shadow_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  cur_bit_s, last_s, expired_s, load_s, adv_s;
  logic [CW-1:0]         load_val_s;
  logic [2*NUM_BITS-1:0] bl_s, wl_s;

  assign cur_bit_s = shadow_r[idx_r];
  assign last_s    = (idx_r == IDX_W'(NUM_BITS - 1));

`ifdef RRAM_PROG_VERIFY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_r;
  logic          match_s, exhausted_s;
  logic          err_r;
  logic [IDX_W-1:0] err_idx_r;

  assign match_s     = (dout_i[idx_r] == cur_bit_s);
  assign exhausted_s = (retry_r >= RW'(MAX_RETRY));
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // next-state and cell-advance decode
  always_comb begin
    next_s = state_r;
    adv_s  = 1'b0;
    case (state_r)
      ST_IDLE:  next_s = start ? ST_SETUP : ST_IDLE;
      ST_SETUP: next_s = expired_s ? ST_PULSE : ST_SETUP;
      ST_PULSE: next_s = expired_s ? ST_HOLD : ST_PULSE;
      ST_HOLD: begin
        if (expired_s) begin
`ifdef RRAM_PROG_VERIFY_EN
          next_s = ST_VERIFY;
`else
          next_s = last_s ? ST_DONE : ST_SETUP;
          adv_s  = !last_s;
`endif
        end else begin
          next_s = ST_HOLD;
        end
      end
`ifdef RRAM_PROG_VERIFY_EN
      ST_VERIFY: begin
        if (match_s || exhausted_s) begin
          next_s = last_s ? ST_DONE : ST_SETUP;
          adv_s  = !last_s;
        end else begin
          next_s = ST_SETUP;
        end
      end
`endif
      ST_DONE:  next_s = ST_IDLE;
      default:  next_s = ST_IDLE;
    endcase
  end

  // phase timer is reloaded whenever the FSM enters a new state
  always_comb begin
    load_s = (next_s != state_r);
    case (next_s)
      ST_SETUP: load_val_s = CW'(SETUP_CYC - 1);
      ST_PULSE: load_val_s = CW'(PULSE_CYC - 1);
      ST_HOLD:  load_val_s = CW'(HOLD_CYC - 1);
      default:  load_val_s = {CW{1'b0}};
    endcase
  end

  prog_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .expired  (expired_s)
  );

  // shadow word capture and cell index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= {NUM_BITS{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
    end else if (state_r == ST_IDLE && start) begin
      shadow_r <= cfg_data;
      idx_r    <= {IDX_W{1'b0}};
    end else if (adv_s) begin
      idx_r    <= idx_r + IDX_W'(1);
    end
  end

`ifdef RRAM_PROG_VERIFY_EN
  // retry counter and sticky first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_r   <= {RW{1'b0}};
      err_r     <= 1'b0;
      err_idx_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_IDLE && start) begin
      retry_r   <= {RW{1'b0}};
      err_r     <= 1'b0;
      err_idx_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_VERIFY) begin
      if (match_s) begin
        retry_r <= {RW{1'b0}};
      end else if (!exhausted_s) begin
        retry_r <= retry_r + RW'(1);
      end else begin
        retry_r <= {RW{1'b0}};
        err_r   <= 1'b1;
        if (!err_r) begin
          err_idx_r <= idx_r;
        end
      end
    end
  end

  assign err     = err_r;
  assign err_idx = err_idx_r;
`else
  assign err     = 1'b0;
  assign err_idx = {IDX_W{1'b0}};
`endif

  // bitline/wordline decode for the current cell; {idx,0} is line[0], {idx,1} is line[1]
  always_comb begin
    bl_s = {(2*NUM_BITS){1'b0}};
    wl_s = {(2*NUM_BITS){1'b0}};
    case (state_r)
      ST_SETUP, ST_HOLD: bl_s[{idx_r, ~cur_bit_s}] = 1'b1;
      ST_PULSE: begin
        bl_s[{idx_r, ~cur_bit_s}] = 1'b1;
        wl_s[{idx_r, cur_bit_s}]  = 1'b1;
      end
      default: begin
        bl_s = {(2*NUM_BITS){1'b0}};
        wl_s = {(2*NUM_BITS){1'b0}};
      end
    endcase
  end

  // registered outputs; busy looks ahead so it rises on the start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl_o <= {(2*NUM_BITS){1'b0}};
      wl_o <= {(2*NUM_BITS){1'b0}};
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      bl_o <= bl_s;
      wl_o <= wl_s;
      busy <= (next_s != ST_IDLE);
      done <= (state_r == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rram_prog_sequencer.sv
// Randomized self-checking bench for rram_prog_sequencer against a cycle-timeline reference model.
// Covers the verify loop as well when RRAM_PROG_VERIFY_EN is defined.
module tb_rram_prog_sequencer;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 1;
  localparam int MR = 3;
`ifdef RRAM_PROG_VERIFY_EN
  localparam int L  = S + P + H + 1;
`else
  localparam int L  = S + P + H;
`endif

  typedef struct packed {
    logic [2*N-1:0] bl;
    logic [2*N-1:0] wl;
    logic           busy;
    logic           done;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   cfg_data;
  logic [N-1:0]   dout_i;
  logic [2*N-1:0] bl_o, wl_o;
  logic           busy, done, err;
  logic [1:0]     err_idx;

  logic [N-1:0]   cell_q = '0;
  logic [N-1:0]   stuck_mask = '0;
  exp_t           exp_q[$];
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  rram_prog_sequencer #(
    .NUM_BITS(N), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .dout_i(dout_i),
    .bl_o(bl_o), .wl_o(wl_o), .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  // behavioural cells: wl[1] writes 1, wl[0] writes 0; stuck cells read back 0
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (wl_o[2*i+1]) cell_q[i] <= 1'b1;
      else if (wl_o[2*i]) cell_q[i] <= 1'b0;
    end
  end
  assign dout_i = cell_q & ~stuck_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected sample after each edge, starting at the start edge
  task automatic build(input logic [N-1:0] d, input logic [N-1:0] stuck);
    exp_t e;
    int att;
    exp_q.delete();
    e = '0; e.busy = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k < N; k++) begin
      att = 1;
`ifdef RRAM_PROG_VERIFY_EN
      if (stuck[k] && d[k]) att = MR + 1;
`endif
      for (int a = 0; a < att; a++) begin
        for (int ph = 0; ph < L; ph++) begin
          e = '0; e.busy = 1'b1;
          if (ph < S + P + H) e.bl[2*k + (d[k] ? 0 : 1)] = 1'b1;
          if (ph >= S && ph < S + P) e.wl[2*k + (d[k] ? 1 : 0)] = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
    e = '0;
    exp_q.push_back(e);
  endtask

  // one full programming run; noisy pokes start and cfg_data while the sequence is busy
  task automatic run(input logic [N-1:0] d, input logic [N-1:0] stuck, input bit noisy,
                     input int abort_at);
    exp_t e;
    int sz;
    logic exp_err;
    int exp_idx;
    build(d, stuck);
    sz = exp_q.size();
    stuck_mask = stuck;
    @(negedge clk);
    cfg_data = d;
    start = 1'b1;
    for (int t = 0; t < sz; t++) begin
      @(posedge clk);
      #1;
      e = exp_q[t];
      chk("seq", {14'd0, bl_o, wl_o, busy, done}, {14'd0, e});
      if (t == 0) chk("err_clr", {31'd0, err}, 32'd0);
      if (t == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bl", {24'd0, bl_o}, 32'd0);
        chk("rst_wl", {24'd0, wl_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (noisy && t <= sz - 3) begin
        start = ($urandom_range(0, 2) == 0);
        cfg_data = N'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    exp_err = 1'b0;
    exp_idx = 0;
`ifdef RRAM_PROG_VERIFY_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (stuck[k] && d[k]) begin
        exp_err = 1'b1;
        exp_idx = k;
      end
    end
`endif
    chk("err_end", {31'd0, err}, {31'd0, exp_err});
    chk("err_idx", {30'd0, err_idx}, 32'(exp_idx));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_data = '0;
    #23;
    chk("rst_out", {12'd0, bl_o, wl_o, busy, done, err, err_idx},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(4'b1010, 4'b0000, 1'b0, -1);
    for (int i = 0; i < 3; i++) run(N'($urandom), 4'b0000, 1'b1, -1);
    // abort during the cell 2 wordline pulse, then restart from cell 0
    run(4'b0101, 4'b0000, 1'b0, 1 + 2 * L + S + 1);
    run(4'b0111, 4'b0000, 1'b1, -1);
`ifdef RRAM_PROG_VERIFY_EN
    run(4'b0110, 4'b0000, 1'b0, -1);
    run(4'b1011, 4'b0010, 1'b0, -1);
    run(4'b1011, 4'b0000, 1'b0, -1);
    run(N'($urandom), N'($urandom), 1'b1, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rram_prog_sequencer.md
# rram_prog_sequencer

Programming sequencer for a column of 2-bitline/2-wordline RRAM configuration cells (`sram6T_rram` style). It captures a configuration word and programs it one cell at a time. Each cell gets a bitline setup phase, a timed wordline pulse and a hold phase. An optional readback-verify-retry loop can follow each cell. It sits between the configuration loader and the configuration-cell array; it is the only driver of the array's `bl`/`wl` nets.

## Interface
- `NUM_BITS`, 16: number of cells programmed, ≥1
- `SETUP_CYC`, 2: cycles bitlines are stable before the wordline rises, ≥1
- `PULSE_CYC`, 4: cycles the wordline is high, ≥1
- `HOLD_CYC`, 1: cycles bitlines stay stable after the wordline falls, ≥1
- `MAX_RETRY`, 3: extra attempts per cell on verify mismatch (verify build only)

- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: request programming; sampled only in IDLE
- `cfg_data` in `NUM_BITS`: target values; bit i goes to cell i
- `dout_i` in `NUM_BITS`: cell readback (`dout` of each cell)
- `bl_o` out `2*NUM_BITS`: cell i bitlines are `bl_o[2i]` (bl[0]) and `bl_o[2i+1]` (bl[1])
- `wl_o` out `2*NUM_BITS`: cell i wordlines are `wl_o[2i]` (wl[0]) and `wl_o[2i+1]` (wl[1])
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when the sequence completes
- `err` out 1: sticky verify failure; cleared on an accepted `start`
- `err_idx` out `$clog2(NUM_BITS)`: index of the first failing cell

## Operation
- All outputs reset to 0. The FSM resets to IDLE. Counters and the shadow register reset to 0.
- States: IDLE, SETUP, PULSE, HOLD, VERIFY (macro only), DONE.
- **IDLE**
  - When `start`=1: capture `cfg_data` into the shadow register, set idx=0, clear retry count, `err` and `err_idx`, then go to SETUP.
  - `start` is ignored in every other state.
  - Later changes to `cfg_data` have no effect.
- **Write mapping for cell idx, target t**
  - t=1: `bl_o[2idx]`=1 and pulse `wl_o[2idx+1]`.
  - t=0: `bl_o[2idx+1]`=1 and pulse `wl_o[2idx]`.
  - All other `bl_o`/`wl_o` bits are 0. At most one `wl_o` bit is ever high.
- **Phases**
  - SETUP lasts `SETUP_CYC` cycles. PULSE lasts `PULSE_CYC` cycles. HOLD lasts `HOLD_CYC` cycles.
  - The bitline is high in SETUP, PULSE and HOLD. The wordline is high in PULSE only.
- **After HOLD**
  - With verify: go to VERIFY.
  - Without verify: if idx=`NUM_BITS`-1, go to DONE; otherwise idx++ and go to SETUP.
- **VERIFY** (1 cycle; bitlines and wordlines low)
  - Compare `dout_i[idx]` with the target.
  - Match: advance as in "After HOLD" and clear the retry count.
  - Mismatch with retry count < `MAX_RETRY`: increment the retry count and go to SETUP for the same idx.
  - Mismatch otherwise: set `err`. Load `err_idx` only if `err` was 0. Then advance.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Reset mid-sequence: all `bl_o`/`wl_o` drop to 0 asynchronously and the sequence is abandoned. No partial-state recovery.

## Timing
- `bl_o`, `wl_o`, `busy`, `done` and `err` are registered. No combinational path from any input to any output.
- Each cell takes S+P+H cycles without verify, or S+P+H+1 per attempt with verify.
- Call the clock edge that samples `start`=1 edge 0. `busy` rises after edge 0.
- Without verify, `done` is high during the cycle after edge `NUM_BITS`·(S+P+H)+1.
- The wordline rises exactly S cycles after its bitline rises and falls H cycles before that bitline falls.

## Configuration
- Macro `RRAM_PROG_VERIFY_EN`.
- **Defined**
  - The VERIFY state and the retry counter exist.
  - `err`/`err_idx` behave as described above.
- **Undefined**
  - There is no VERIFY state; `dout_i` is unused.
  - `err` and `err_idx` are tied to 0.
  - `MAX_RETRY` is ignored.
- The port list is identical in both builds.

## Structure
- Package `rram_prog_pkg`: state enum `prog_state_e`, and default phase-length constants.
- Sub-module `prog_phase_timer`: a loadable down-counter, wide enough for max(S,P,H). It is loaded on each phase entry and flags expiry. The FSM, index counter and retry counter stay in the top module.

## Test plan
- **Basic sequence.** `NUM_BITS`=4, S=2, P=4, H=1, no verify, `cfg_data`=4'b1010.
  - Cell 0 gets `bl_o[1]` and `wl_o[0]`; cell 1 gets `bl_o[2]` and `wl_o[3]`.
  - Each wordline is high for 4 cycles.
  - `done` goes high 29 cycles after the start edge.
- **Overlap checks.**
  - `start` pulsed while busy, with `cfg_data` changed mid-run: no restart, and the original value is programmed.
  - `wl_o` is never high on more than one bit.
- **Reset mid-pulse.** `rst_n`=0 during cell 2 PULSE.
  - `bl_o`/`wl_o`/`busy` go to 0 immediately.
  - After release, a new `start` programs from cell 0.
- **Verify, clean run.** Verify build with behavioural cell models on `dout_i`, `cfg_data`=4'b0110: `err`=0, and `done` arrives after 4·8+1=33 cycles.
- **Verify, stuck cell.** Verify build with cell 1 `dout` stuck at 0 and target 1.
  - Cell 1 is attempted 4 times.
  - `err`=1 and `err_idx`=1; the remaining cells are still programmed and `done` pulses.
- **Error clear.** Start a new run after the stuck-cell failure with cell 1 fixed: `err` clears on the accepted `start`.
